// File: rtl/motor_drive_seq.sv
// Run/reverse/overcurrent sequencer between the command front end and the H-bridge.
// Soft-ramps the duty command, inserts a dead interval on reversal, and enforces a trip/cooldown/lockout policy.
module motor_drive_seq #(
    parameter int RAMP_DIV     = 50000,
    parameter int DEAD_CYC     = 1000,
    parameter int COOLDOWN_CYC = 5000000,
    parameter int MAX_RETRY    = 3,
    parameter int OC_FILTER    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       dir_cmd,
    input  logic [7:0] duty_tgt,
    input  logic [1:0] OC,
    output logic [7:0] duty_cmd,
    output logic [3:0] IN,
    output logic [1:0] EN,
    output logic       fault,
    output logic [1:0] retry_cnt,
    output logic [2:0] state
);

    localparam int STEP_W  = $clog2(RAMP_DIV + 1);
    localparam int TMR_MAX = (DEAD_CYC > COOLDOWN_CYC) ? DEAD_CYC : COOLDOWN_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int OC_W    = $clog2(OC_FILTER + 1);

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(RAMP_DIV - 1);
    localparam logic [TMR_W-1:0]  DEAD_LAST = TMR_W'(DEAD_CYC - 1);
    localparam logic [TMR_W-1:0]  COOL_LAST = TMR_W'(COOLDOWN_CYC - 1);
    localparam logic [OC_W-1:0]   OC_LAST   = OC_W'(OC_FILTER - 1);
    localparam logic [1:0]        RETRY_MAX = 2'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RAMP = 3'd1,
        S_RUN  = 3'd2,
        S_DEAD = 3'd3,
        S_COOL = 3'd4,
        S_LOCK = 3'd5
    } state_t;

    state_t              cur_state, nxt_state;
    logic                dir_lat, dir_lat_nxt;
    logic                rev_pend, rev_pend_nxt;
    logic [STEP_W-1:0]   step_cnt, step_cnt_nxt;
    logic [TMR_W-1:0]    tmr, tmr_nxt;
    logic [OC_W-1:0]     oc_cnt, oc_cnt_nxt;
    logic [7:0]          duty_nxt;
    logic [7:0]          eff_tgt;
    logic [1:0]          retry_nxt;
    logic [1:0]          en_nxt;
    logic [3:0]          in_nxt;
    logic                fault_nxt;
    logic                driving, drive_nxt, oc_trip;

    // One-LSB move toward the target; never wraps past 0 or 255.
    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt) return cur + 8'd1;
        if (cur > tgt) return cur - 8'd1;
        return cur;
    endfunction

    always_comb begin
        nxt_state    = cur_state;
        dir_lat_nxt  = dir_lat;
        rev_pend_nxt = rev_pend;
        step_cnt_nxt = '0;
        tmr_nxt      = '0;
        oc_cnt_nxt   = '0;
        duty_nxt     = duty_cmd;
        retry_nxt    = retry_cnt;
        oc_trip      = 1'b0;
        driving      = (cur_state == S_RAMP) || (cur_state == S_RUN);
        eff_tgt      = rev_pend ? 8'd0 : duty_tgt;

        if (driving && (OC != 2'b00)) begin
            if (oc_cnt == OC_LAST) oc_trip = 1'b1;
            else                   oc_cnt_nxt = oc_cnt + 1'b1;
        end

        if (cur_state == S_RAMP) begin
            if (step_cnt == STEP_LAST) duty_nxt = step_toward(duty_cmd, eff_tgt);
            else                       step_cnt_nxt = step_cnt + 1'b1;
        end

        case (cur_state)
            S_IDLE: begin
                if (enable) begin
                    nxt_state    = S_RAMP;
                    dir_lat_nxt  = dir_cmd;
                    rev_pend_nxt = 1'b0;
                end
            end
            S_RAMP: begin
                if (rev_pend && (duty_cmd == 8'd0))         nxt_state = S_DEAD;
                else if (!rev_pend && (duty_cmd == duty_tgt)) nxt_state = S_RUN;
            end
            S_RUN: begin
                if (dir_cmd != dir_lat) begin
                    rev_pend_nxt = 1'b1;
                    nxt_state    = S_RAMP;
                end else if (duty_tgt != duty_cmd) begin
                    nxt_state = S_RAMP;
                end
            end
            S_DEAD: begin
                if (tmr == DEAD_LAST) begin
                    nxt_state    = S_RAMP;
                    dir_lat_nxt  = dir_cmd;
                    rev_pend_nxt = 1'b0;
                    duty_nxt     = 8'd0;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            S_COOL: begin
                if (tmr == COOL_LAST) begin
                    if (retry_cnt == RETRY_MAX) nxt_state = S_LOCK;
                    else if (enable)            nxt_state = S_RAMP;
                    else                        nxt_state = S_IDLE;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            S_LOCK:  ;
            default: nxt_state = S_IDLE;
        endcase

        // Later overrides win: trip beats reversal/duty change, enable=0 beats everything.
        if (oc_trip) begin
            nxt_state = S_COOL;
            if (retry_cnt != 2'd3) retry_nxt = retry_cnt + 2'd1;
        end
        if (!enable && (cur_state != S_IDLE)) nxt_state = S_IDLE;

        if (nxt_state == S_IDLE) begin
            duty_nxt     = 8'd0;
            retry_nxt    = 2'd0;
            rev_pend_nxt = 1'b0;
        end
        if (nxt_state == S_COOL)      duty_nxt = 8'd0;
        if (nxt_state != S_RAMP)      step_cnt_nxt = '0;
        if (nxt_state != cur_state)   tmr_nxt = '0;

        drive_nxt = (nxt_state == S_RAMP) || (nxt_state == S_RUN);
        en_nxt    = drive_nxt ? 2'b11 : 2'b00;
        in_nxt    = drive_nxt ? (dir_lat_nxt ? 4'b0101 : 4'b1010) : 4'b0000;
        fault_nxt = (nxt_state == S_COOL) || (nxt_state == S_LOCK);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state <= S_IDLE;
            dir_lat   <= 1'b0;
            rev_pend  <= 1'b0;
            step_cnt  <= '0;
            tmr       <= '0;
            oc_cnt    <= '0;
            duty_cmd  <= 8'd0;
            retry_cnt <= 2'd0;
            EN        <= 2'b00;
            IN        <= 4'b0000;
            fault     <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            dir_lat   <= dir_lat_nxt;
            rev_pend  <= rev_pend_nxt;
            step_cnt  <= step_cnt_nxt;
            tmr       <= tmr_nxt;
            oc_cnt    <= oc_cnt_nxt;
            duty_cmd  <= duty_nxt;
            retry_cnt <= retry_nxt;
            EN        <= en_nxt;
            IN        <= in_nxt;
            fault     <= fault_nxt;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_motor_drive_seq.sv
// Bench for motor_drive_seq: directed scenarios plus randomized traffic against a behavioural model.
module tb_motor_drive_seq;

    localparam int RAMP_DIV     = 4;
    localparam int DEAD_CYC     = 8;
    localparam int COOLDOWN_CYC = 20;
    localparam int MAX_RETRY    = 3;
    localparam int OC_FILTER    = 3;

    logic       clk = 1'b0;
    logic       rst_n, enable, dir_cmd;
    logic [7:0] duty_tgt;
    logic [1:0] OC;
    logic [7:0] duty_cmd;
    logic [3:0] IN;
    logic [1:0] EN;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [2:0] state;
    logic [19:0] obs;

    int checks = 0;
    int errors = 0;

    // Behavioural model: states by their display codes, timers as plain countdowns.
    int m_state, m_duty, m_phase, m_hold, m_oc, m_retry;
    bit m_dir, m_pend;
    logic [3:0] prev_in;

    motor_drive_seq #(
        .RAMP_DIV(RAMP_DIV), .DEAD_CYC(DEAD_CYC), .COOLDOWN_CYC(COOLDOWN_CYC),
        .MAX_RETRY(MAX_RETRY), .OC_FILTER(OC_FILTER)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .dir_cmd(dir_cmd),
        .duty_tgt(duty_tgt), .OC(OC), .duty_cmd(duty_cmd), .IN(IN), .EN(EN),
        .fault(fault), .retry_cnt(retry_cnt), .state(state)
    );

    always #5 clk = ~clk;

    assign obs = {state, duty_cmd, IN, EN, fault, retry_cnt};

    function automatic logic [19:0] exp_vec();
        logic [3:0] e_in;
        logic [1:0] e_en;
        logic       e_f;
        bit         drv;
        drv  = (m_state == 1) || (m_state == 2);
        e_in = drv ? (m_dir ? 4'b0101 : 4'b1010) : 4'b0000;
        e_en = drv ? 2'b11 : 2'b00;
        e_f  = (m_state == 4) || (m_state == 5);
        return {3'(m_state), 8'(m_duty), e_in, e_en, e_f, 2'(m_retry)};
    endfunction

    task automatic model_clock(input logic rn, input logic en, input logic dc,
                               input logic [7:0] tgt, input logic [1:0] oc);
        int s, d, eff, ns, nd, ocn;
        bit pend;
        if (!rn) begin
            m_state = 0; m_duty = 0; m_dir = 0; m_pend = 0;
            m_phase = 0; m_hold = 0; m_oc = 0; m_retry = 0;
            return;
        end
        s = m_state; d = m_duty; pend = m_pend;
        eff = pend ? 0 : int'(tgt);
        ns = s; nd = d;
        ocn = ((s == 1 || s == 2) && oc != 2'b00) ? m_oc + 1 : 0;
        if (s == 1) begin
            m_phase++;
            if (m_phase % RAMP_DIV == 0) begin
                if (d < eff) nd = d + 1;
                else if (d > eff) nd = d - 1;
            end
        end
        case (s)
            0: if (en) begin ns = 1; m_dir = dc; m_pend = 0; end
            1: begin
                if (pend && d == 0) ns = 3;
                else if (!pend && d == int'(tgt)) ns = 2;
            end
            2: begin
                if (dc != m_dir) begin m_pend = 1; ns = 1; end
                else if (int'(tgt) != d) ns = 1;
            end
            3: begin
                m_hold--;
                if (m_hold == 0) begin ns = 1; m_dir = dc; m_pend = 0; nd = 0; end
            end
            4: begin
                m_hold--;
                if (m_hold == 0) begin
                    if (m_retry == MAX_RETRY) ns = 5;
                    else if (en) ns = 1;
                    else ns = 0;
                end
            end
            5: ;
            default: ns = 0;
        endcase
        if (ocn >= OC_FILTER) begin ns = 4; m_retry++; ocn = 0; end
        if (!en && s != 0) ns = 0;
        if (ns == 0) begin nd = 0; m_retry = 0; m_pend = 0; end
        if (ns == 4) nd = 0;
        if (ns != s) begin
            if (ns == 1) m_phase = 0;
            if (ns == 3) m_hold = DEAD_CYC;
            if (ns == 4) m_hold = COOLDOWN_CYC;
        end
        m_state = ns; m_duty = nd; m_oc = ocn;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_clock(rst_n, enable, dir_cmd, duty_tgt, OC);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; dir_cmd = 1'b0; duty_tgt = 8'd0; OC = 2'b00;
        cycle(); cycle();
        checks++;
        if (obs !== 20'h0) begin errors++; $display("FAIL reset_state got %h want %h", obs, 20'h0); end
        rst_n = 1'b1;
        cycle();
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL reset_idle got %h want %h", obs, exp_vec()); end
    endtask

    task automatic test_ramp_up();
        int want;
        enable = 1'b1; dir_cmd = 1'b0; duty_tgt = 8'd5;
        for (int n = 1; n <= 22; n++) begin
            cycle();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL ramp_model n=%0d got %h want %h", n, obs, exp_vec()); end
            want = (n - 1) / RAMP_DIV;
            if (want > 5) want = 5;
            checks++;
            if (duty_cmd !== 8'(want)) begin errors++; $display("FAIL ramp_duty n=%0d got %0d want %0d", n, duty_cmd, want); end
            if (n == 1) begin
                checks++;
                if ({IN, EN} !== {4'b1010, 2'b11}) begin errors++; $display("FAIL ramp_bridge got %b/%b want 1010/11", IN, EN); end
            end
        end
        checks++;
        if (state !== 3'd2) begin errors++; $display("FAIL ramp_run got %0d want 2", state); end
    endtask

    task automatic test_reversal();
        int off_cnt;
        bit done;
        off_cnt = 0; done = 0;
        prev_in = IN;
        dir_cmd = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            cycle();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL rev_model n=%0d got %h want %h", n, obs, exp_vec()); end
            checks++;
            if (EN == 2'b11 && IN == 4'b0000) begin errors++; $display("FAIL rev_en_no_in n=%0d got EN=%b IN=%b", n, EN, IN); end
            checks++;
            if ((prev_in == 4'b1010 && IN == 4'b0101) || (prev_in == 4'b0101 && IN == 4'b1010)) begin
                errors++; $display("FAIL rev_direct_flip n=%0d got %b->%b", n, prev_in, IN);
            end
            if (EN == 2'b00) off_cnt++;
            prev_in = IN;
            if (m_state == 2 && m_dir) done = 1;
        end
        checks++;
        if (!done) begin errors++; $display("FAIL rev_timeout got state %0d want RUN", state); end
        checks++;
        if (off_cnt != DEAD_CYC) begin errors++; $display("FAIL rev_dead_len got %0d want %0d", off_cnt, DEAD_CYC); end
        checks++;
        if ({IN, EN, duty_cmd} !== {4'b0101, 2'b11, 8'd5}) begin
            errors++; $display("FAIL rev_final got %b/%b/%0d want 0101/11/5", IN, EN, duty_cmd);
        end
    endtask

    task automatic test_oc();
        bit done;
        OC = 2'b01; cycle(); cycle();
        OC = 2'b00; cycle();
        checks++;
        if (state !== 3'd2 || fault !== 1'b0) begin errors++; $display("FAIL oc_glitch got state %0d fault %b want 2/0", state, fault); end
        OC = 2'b10; cycle(); cycle(); cycle();
        checks++;
        if ({state, EN, IN, duty_cmd, fault, retry_cnt} !== {3'd4, 2'b00, 4'b0000, 8'd0, 1'b1, 2'd1}) begin
            errors++; $display("FAIL oc_trip got st=%0d en=%b in=%b d=%0d f=%b r=%0d want 4/00/0000/0/1/1",
                               state, EN, IN, duty_cmd, fault, retry_cnt);
        end
        OC = 2'b00;
        for (int k = 1; k <= COOLDOWN_CYC; k++) begin
            cycle();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL oc_cool_model k=%0d got %h want %h", k, obs, exp_vec()); end
            if (k == COOLDOWN_CYC - 1) begin
                checks++;
                if (state !== 3'd4) begin errors++; $display("FAIL oc_cool_hold got %0d want 4", state); end
            end
        end
        checks++;
        if (state !== 3'd1) begin errors++; $display("FAIL oc_retry_ramp got %0d want 1", state); end
        done = 0;
        for (int n = 0; n < 100 && !done; n++) begin
            cycle();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL oc_reramp n=%0d got %h want %h", n, obs, exp_vec()); end
            if (m_state == 2) done = 1;
        end
    endtask

    task automatic test_lockout();
        enable = 1'b0; cycle();
        checks++;
        if (state !== 3'd0 || retry_cnt !== 2'd0) begin errors++; $display("FAIL lk_idle got %0d/%0d want 0/0", state, retry_cnt); end
        enable = 1'b1; cycle();
        for (int k = 1; k <= 3; k++) begin
            OC = 2'b11;
            repeat (OC_FILTER) cycle();
            checks++;
            if (state !== 3'd4 || retry_cnt !== 2'(k)) begin
                errors++; $display("FAIL lk_trip k=%0d got %0d/%0d want 4/%0d", k, state, retry_cnt, k);
            end
            OC = 2'b00;
            repeat (COOLDOWN_CYC) cycle();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL lk_after_cool k=%0d got %h want %h", k, obs, exp_vec()); end
            checks++;
            if (state !== ((k == 3) ? 3'd5 : 3'd1)) begin errors++; $display("FAIL lk_exit k=%0d got %0d", k, state); end
        end
        for (int n = 0; n < 10; n++) begin
            OC = 2'($urandom_range(0, 3));
            duty_tgt = 8'($urandom);
            dir_cmd = ~dir_cmd;
            cycle();
            checks++;
            if ({state, EN, IN, fault, retry_cnt} !== {3'd5, 2'b00, 4'b0000, 1'b1, 2'd3}) begin
                errors++; $display("FAIL lk_hold n=%0d got st=%0d en=%b f=%b r=%0d want 5/00/1/3", n, state, EN, fault, retry_cnt);
            end
        end
        OC = 2'b00; enable = 1'b0; cycle();
        checks++;
        if ({state, retry_cnt, fault} !== {3'd0, 2'd0, 1'b0}) begin
            errors++; $display("FAIL lk_release got %0d/%0d/%b want 0/0/0", state, retry_cnt, fault);
        end
    endtask

    task automatic test_saturate();
        bit done;
        int prev;
        dir_cmd = 1'b0; duty_tgt = 8'd255; OC = 2'b00; enable = 1'b1;
        done = 0;
        for (int n = 0; n < 1200 && !done; n++) begin
            cycle();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL sat_up n=%0d got %h want %h", n, obs, exp_vec()); end
            if (m_state == 2) done = 1;
        end
        checks++;
        if (duty_cmd !== 8'd255 || state !== 3'd2) begin errors++; $display("FAIL sat_top got %0d/%0d want 255/2", duty_cmd, state); end
        duty_tgt = 8'd0; prev = 255; done = 0;
        for (int n = 0; n < 1200 && !done; n++) begin
            cycle();
            checks++;
            if (int'(duty_cmd) > prev || prev - int'(duty_cmd) > 1) begin
                errors++; $display("FAIL sat_nowrap n=%0d got %0d after %0d", n, duty_cmd, prev);
            end
            prev = int'(duty_cmd);
            if (m_state == 2) done = 1;
        end
        checks++;
        if ({duty_cmd, state, EN} !== {8'd0, 3'd2, 2'b11}) begin
            errors++; $display("FAIL sat_bottom got %0d/%0d/%b want 0/2/11", duty_cmd, state, EN);
        end
        enable = 1'b0; cycle();
        checks++;
        if (state !== 3'd0 || EN !== 2'b00) begin errors++; $display("FAIL sat_stop got %0d/%b want 0/00", state, EN); end
    endtask

    task automatic test_reset_mid();
        enable = 1'b1; duty_tgt = 8'd50; dir_cmd = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            OC = (n >= 5) ? 2'b01 : 2'b00;
            cycle();
        end
        rst_n = 1'b0; OC = 2'b00;
        cycle();
        checks++;
        if (obs !== 20'h0) begin errors++; $display("FAIL mid_reset got %h want %h", obs, 20'h0); end
        rst_n = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            OC = (n <= 2) ? 2'b01 : 2'b00;
            cycle();
            checks++;
            if (duty_cmd !== 8'((n - 1) / RAMP_DIV) || state !== 3'd1) begin
                errors++; $display("FAIL mid_restart n=%0d got %0d/%0d want %0d/1", n, duty_cmd, state, (n - 1) / RAMP_DIV);
            end
        end
    endtask

    task automatic test_random();
        int burst;
        burst = 0;
        prev_in = IN;
        for (int n = 0; n < 3000; n++) begin
            rst_n  = ($urandom_range(0, 699) != 0);
            enable = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 39) == 0) dir_cmd = ~dir_cmd;
            if ($urandom_range(0, 29) == 0) duty_tgt = 8'($urandom_range(0, 10));
            if (burst == 0 && $urandom_range(0, 49) == 0) burst = $urandom_range(1, 4);
            if (burst > 0) begin OC = 2'($urandom_range(1, 3)); burst--; end
            else OC = 2'b00;
            cycle();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL rnd_model n=%0d got %h want %h", n, obs, exp_vec()); end
            checks++;
            if ((EN == 2'b11 && IN == 4'b0000) ||
                (prev_in == 4'b1010 && IN == 4'b0101) || (prev_in == 4'b0101 && IN == 4'b1010)) begin
                errors++; $display("FAIL rnd_bridge n=%0d got EN=%b IN=%b prev=%b", n, EN, IN, prev_in);
            end
            prev_in = IN;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_reversal();
        test_oc();
        test_lockout();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/motor_drive_seq.md
Name: motor_drive_seq

Overview:
- Sequencer between the switch/command front end and the H-bridge/PWM datapath.
- Soft-starts and soft-stops the PWM duty command and inserts a dead interval on every direction reversal.
- Filters the bridge overcurrent inputs, then runs a cooldown/retry policy that ends in a latched lockout.
- Drives both bridge channels identically. Its status outputs feed the seven-segment display.

Parameters:
RAMP_DIV, 50000, clock cycles per 1-LSB duty step during ramping (>=1)
DEAD_CYC, 1000, cycles the bridge is held off (EN=00, IN=0000) between directions (>=1)
COOLDOWN_CYC, 5000000, cycles held off after an overcurrent trip (>=1)
MAX_RETRY, 3, overcurrent trips allowed before lockout (1..3)
OC_FILTER, 16, consecutive cycles OC must be asserted to count as a trip (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous reset, active-low; one clock, sampled on rising edge of clk
enable  input  1  run request
dir_cmd  input  1  requested direction: 0 forward, 1 reverse
duty_tgt  input  8  target duty, 0..255
OC  input  2  overcurrent flags from bridge, active-high, already synchronous to clk
duty_cmd  output  8  duty to the PWM generator
IN  output  4  bridge inputs
EN  output  2  bridge enables
fault  output  1  high in COOL and LOCKOUT
retry_cnt  output  2  trips since last IDLE
state  output  3  encoded state, for display

Behaviour:
- All outputs are registered. rst_n=0 at a clk edge gives:
  - state=IDLE(0), duty_cmd=0, IN=0000, EN=00, fault=0, retry_cnt=0
  - internal dir latch=0, all counters=0
- State encodings: IDLE=0, RAMP=1, RUN=2, DEAD=3, COOL=4, LOCKOUT=5. Codes 6 and 7 go to IDLE.
- Bridge drive:
  - RAMP/RUN: EN=11; IN=1010 when dir latch=0, IN=0101 when dir latch=1.
  - All other states: EN=00, IN=0000.
  - No cycle ever has EN=11 with IN=0000, or an IN change from 1010 directly to 0101 (or back).
- Ramp engine:
  - Effective target = 0 when a reversal is pending, else duty_tgt.
  - The step counter counts RAMP_DIV cycles. At terminal count, duty_cmd moves 1 toward the effective target (saturating, no wrap) and the counter reloads.
- IDLE:
  - duty_cmd=0, retry_cnt cleared.
  - enable=1 -> latch dir_cmd, go to RAMP.
- RAMP:
  - duty_cmd==duty_tgt and no reversal pending -> RUN.
  - Reversal pending and duty_cmd==0 -> DEAD.
- RUN:
  - Any change in duty_tgt -> RAMP.
  - dir_cmd != dir latch -> set reversal pending, go to RAMP.
- DEAD:
  - Hold for DEAD_CYC cycles.
  - Then latch dir_cmd, clear pending, go to RAMP, with duty starting at 0.
- enable=0 in RAMP/RUN/DEAD or COOL -> next cycle IDLE, duty_cmd=0. This is an immediate stop, not a ramp-down.
- OC filter:
  - Counter increments while (OC!=00) in RAMP/RUN, and clears when OC==00 or in any other state.
  - When it reaches OC_FILTER on cycle N, cycle N+1 has state=COOL, EN=00, IN=0000, duty_cmd=0, retry_cnt+1, fault=1.
- COOL:
  - Hold COOLDOWN_CYC cycles. Then:
    - retry_cnt==MAX_RETRY -> LOCKOUT
    - else enable=1 -> RAMP (from duty 0, same dir latch)
    - else IDLE
- LOCKOUT:
  - fault=1, bridge off. Ignores OC, duty_tgt and dir_cmd.
  - Exits to IDLE only on enable=0.
- Simultaneous events, highest priority first: rst_n, enable=0, OC trip, reversal, duty change.
- Reset mid-operation takes effect at the next edge regardless of state or counters.

Test Plan:
Bench parameters: RAMP_DIV=4, DEAD_CYC=8, COOLDOWN_CYC=20, MAX_RETRY=3, OC_FILTER=3.
1. Reset, then enable=1, dir_cmd=0, duty_tgt=5 -> IN=1010, EN=11; duty_cmd steps 0,1,...,5, one step per 4 cycles; state=RUN once duty_cmd=5.
2. In RUN at duty 5, toggle dir_cmd=1 -> duty ramps to 0, then 8 cycles of EN=00/IN=0000, then IN=0101, EN=11, ramp back to 5. No cycle shows EN=11 with IN=0000, and IN never goes 1010->0101 directly.
3. In RUN, OC=01 for 2 cycles then 00 -> no trip. OC=10 held for 3 cycles -> next cycle state=COOL, EN=00, duty_cmd=0, fault=1, retry_cnt=1; after 20 cycles back in RAMP.
4. Trip three times with enable held high -> after third cooldown state=LOCKOUT, retry_cnt=3, fault=1. Drop enable -> IDLE, retry_cnt=0, fault=0.
5. duty_tgt=255 with duty_cmd at 255, then duty_tgt=0 -> duty_cmd decrements without wrap, ends at 0 in RUN with EN=11. Then enable=0 -> next cycle IDLE, EN=00.
6. Assert rst_n=0 for one cycle during RAMP with step and OC counters mid-count -> all outputs at reset values next cycle. A subsequent start ramps from 0 with full RAMP_DIV spacing.
